// File: rtl/thinpad_pkg.sv
// thinpad_pkg: address map, CPU bus request type, sequencer states and UART timing for the Thinpad SoC
package thinpad_pkg;
  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int BAUD_RATE = 115_200;
  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [9:0] BASE_TAG = 10'h200;
  localparam logic [9:0] EXT_TAG = 10'h201;
  localparam logic [31:0] UART_DATA = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT = 32'hBFD0_03FC;
  localparam logic [31:0] LED_ADDR = 32'hBFD0_0400;
  typedef struct packed {
    logic req;
    logic we;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
  } bus_req_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, IO} seq_t;
endpackage

// File: rtl/uart_8n1.sv
// uart_8n1: 8N1 transmitter plus receiver that samples each bit at mid-period
module uart_8n1 import thinpad_pkg::*; #(
  parameter int DIV = BAUD_DIV
) (
  input logic clk,
  input logic rst,
  input logic tx_start,
  input logic [7:0] tx_data,
  output logic tx_idle,
  output logic txd,
  input logic rxd,
  output logic [7:0] rx_data,
  output logic rx_valid
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  logic [9:0] tx_sh;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [3:0] tx_bit, rx_bit;
  logic tx_busy, rx_busy;
  logic [1:0] rx_s;
  logic [7:0] rx_sh;
  assign tx_idle = !tx_busy;
  assign txd = tx_sh[0];
  // the shift register refills with ones, so txd idles high once the frame drains
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_busy <= 1'b0;
      tx_sh <= '1;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx_sh <= {1'b1, tx_data, 1'b0};
        tx_cnt <= '0;
        tx_bit <= '0;
      end
    end else if (tx_cnt == LAST) begin
      tx_cnt <= '0;
      tx_sh <= {1'b1, tx_sh[9:1]};
      tx_bit <= tx_bit + 4'd1;
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
    end else tx_cnt <= tx_cnt + 1'b1;
  // bit 0 is the start bit: a high sample there means a glitch, so give up
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_s <= 2'b11;
      rx_busy <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s <= {rx_s[0], rxd};
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s[1]) begin
          rx_busy <= 1'b1;
          rx_cnt <= HALF;
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
      else begin
        rx_cnt <= LAST;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s[1]) begin
            rx_data <= rx_sh;
            rx_valid <= 1'b1;
          end
        end else if (rx_bit == 4'd0 && rx_s[1]) rx_busy <= 1'b0;
        else rx_sh <= {rx_s[1], rx_sh[7:1]};
      end
    end
endmodule

// File: rtl/thinpad_soc.sv
// thinpad_soc: board top bridging the CPU bus to BaseRAM/ExtRAM, UART and LEDs; flash and displays tied off
module thinpad_soc import thinpad_pkg::*; #(
  parameter int CLK_FREQ = CLK_FREQ_HZ,
  parameter int BAUD = BAUD_RATE
) (
  input logic clk_50M,
  input logic clk_11M0592,
  input logic clock_btn,
  input logic reset_btn,
  input logic [3:0] touch_btn,
  input logic [31:0] dip_sw,
  output logic [15:0] leds,
  output logic [7:0] dpy0,
  output logic [7:0] dpy1,
  output logic txd,
  input logic rxd,
  inout wire [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0] base_ram_be_n,
  output logic base_ram_ce_n,
  output logic base_ram_oe_n,
  output logic base_ram_we_n,
  inout wire [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0] ext_ram_be_n,
  output logic ext_ram_ce_n,
  output logic ext_ram_oe_n,
  output logic ext_ram_we_n,
  output logic [22:0] flash_a,
  inout wire [15:0] flash_d,
  output logic flash_rp_n,
  output logic flash_vpen,
  output logic flash_ce_n,
  output logic flash_oe_n,
  output logic flash_we_n,
  output logic flash_byte_n
);
  logic clk, rst;
  assign clk = clk_50M;
  assign rst = reset_btn;
  bus_req_t cpu_req;
  logic [31:0] cpu_rdata;
  logic cpu_ready;
  // CPU core bus master attaches here; the bus stays idle without it
  assign cpu_req = '0;
  seq_t state, state_n;
  logic sel_ext, op_we, drive, tx_start, tx_idle, rx_valid, rx_avail;
  logic is_base, is_ext, take;
  logic [3:0] op_be;
  logic [19:0] ram_addr;
  logic [31:0] wdata_q, rdata_q, io_rdata;
  logic [7:0] rx_data;
  logic unused;
  assign unused = ^{clk_11M0592, clock_btn, touch_btn, dip_sw, cpu_rdata, cpu_ready, flash_d};
  assign is_base = cpu_req.addr[31:22] == BASE_TAG;
  assign is_ext = cpu_req.addr[31:22] == EXT_TAG;
  assign take = state == IDLE && cpu_req.req;
  assign tx_start = take && cpu_req.we && cpu_req.addr == UART_DATA;
  assign io_rdata = cpu_req.addr == UART_DATA ? {24'h0, rx_data} :
                    cpu_req.addr == UART_STAT ? {30'h0, rx_avail, tx_idle} :
                    cpu_req.addr == LED_ADDR ? {16'h0, leds} : 32'h0;
  assign cpu_ready = state == DONE || state == IO;
  assign cpu_rdata = rdata_q;
  assign base_ram_addr = ram_addr;
  assign ext_ram_addr = ram_addr;
  assign base_ram_data = drive && !sel_ext ? wdata_q : 32'hz;
  assign ext_ram_data = drive && sel_ext ? wdata_q : 32'hz;
  assign dpy0 = '0;
  assign dpy1 = '0;
  assign flash_a = '0;
  assign flash_d = 16'hz;
  assign flash_rp_n = 1'b1;
  assign flash_vpen = 1'b1;
  assign flash_ce_n = 1'b1;
  assign flash_oe_n = 1'b1;
  assign flash_we_n = 1'b1;
  assign flash_byte_n = 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // write data stays on the bus through DONE so we_n rises with address and data stable
  always_comb begin
    state_n = state == IDLE ? (cpu_req.req ? (is_base || is_ext ? ACCESS : IO) : IDLE) :
              state == ACCESS ? DONE : IDLE;
    drive = op_we && (state == ACCESS || state == DONE);
    base_ram_ce_n = !(state == ACCESS && !sel_ext);
    base_ram_oe_n = base_ram_ce_n || op_we;
    base_ram_we_n = base_ram_ce_n || !op_we;
    base_ram_be_n = drive && !sel_ext ? ~op_be : 4'h0;
    ext_ram_ce_n = !(state == ACCESS && sel_ext);
    ext_ram_oe_n = ext_ram_ce_n || op_we;
    ext_ram_we_n = ext_ram_ce_n || !op_we;
    ext_ram_be_n = drive && sel_ext ? ~op_be : 4'h0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_ext <= 1'b0;
      op_we <= 1'b0;
      op_be <= '0;
      ram_addr <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      leds <= '0;
      rx_avail <= 1'b0;
    end else begin
      if (take && (is_base || is_ext)) begin
        sel_ext <= is_ext;
        op_we <= cpu_req.we;
        op_be <= cpu_req.be;
        ram_addr <= cpu_req.addr[21:2];
        wdata_q <= cpu_req.wdata;
      end
      if (take) rdata_q <= io_rdata;
      if (state == ACCESS && !op_we) rdata_q <= sel_ext ? ext_ram_data : base_ram_data;
      if (take && cpu_req.we && cpu_req.addr == LED_ADDR)
        leds <= {cpu_req.be[1] ? cpu_req.wdata[15:8] : leds[15:8], cpu_req.be[0] ? cpu_req.wdata[7:0] : leds[7:0]};
      if (take && !cpu_req.we && cpu_req.addr == UART_DATA) rx_avail <= 1'b0;
      if (rx_valid) rx_avail <= 1'b1;
    end
  uart_8n1 #(.DIV(CLK_FREQ / BAUD)) u_uart (
    .clk(clk),
    .rst(rst),
    .tx_start(tx_start),
    .tx_data(cpu_req.wdata[7:0]),
    .tx_idle(tx_idle),
    .txd(txd),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid)
  );
endmodule

// File: tb/tb_thinpad_soc.sv
// tb_thinpad_soc: directed checks of RAM sequencing, UART, LEDs and reset on the Thinpad top
`define CHK(tag, obs, exp) begin assert ((obs) === (exp)) npass++; else begin nfail++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end end
module tb_thinpad_soc;
  import thinpad_pkg::*;
  logic clk_50M = 0, clk_11M0592 = 0, clock_btn = 0, reset_btn = 0, rxd = 1;
  logic [3:0] touch_btn = '0;
  logic [31:0] dip_sw = '0;
  wire [15:0] leds;
  wire [7:0] dpy0, dpy1;
  wire txd;
  wire [31:0] base_ram_data, ext_ram_data;
  wire [19:0] base_ram_addr, ext_ram_addr;
  wire [3:0] base_ram_be_n, ext_ram_be_n;
  wire base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  wire [22:0] flash_a;
  wire [15:0] flash_d;
  wire flash_rp_n, flash_vpen, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n;
  logic [31:0] base_mem [0:255];
  logic [31:0] ext_mem [0:255];
  int npass = 0, nfail = 0, cyc = 0, lat = 0, e0 = 0;
  bus_req_t req_v;
  logic [31:0] rd, snap_edata;
  logic [2:0] snap_base, snap_ext;
  logic [19:0] snap_baddr, snap_eaddr;
  logic [3:0] snap_ebe;
  logic [9:0] frame;

  thinpad_soc dut (
    .clk_50M(clk_50M), .clk_11M0592(clk_11M0592), .clock_btn(clock_btn), .reset_btn(reset_btn),
    .touch_btn(touch_btn), .dip_sw(dip_sw), .leds(leds), .dpy0(dpy0), .dpy1(dpy1),
    .txd(txd), .rxd(rxd),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .flash_a(flash_a), .flash_d(flash_d), .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen),
    .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n), .flash_byte_n(flash_byte_n)
  );

  initial forever #10 clk_50M = ~clk_50M;

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[7:0]] : 32'hz;
  assign ext_ram_data = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[7:0]] : 32'hz;

  always @(posedge clk_50M) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[i]) base_mem[base_ram_addr[7:0]][i*8 +: 8] <= base_ram_data[i*8 +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[i]) ext_mem[ext_ram_addr[7:0]][i*8 +: 8] <= ext_ram_data[i*8 +: 8];
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk_50M); #1;
    req_v = '{req: 1'b1, we: w, addr: a, be: b, wdata: d};
    force dut.cpu_req = req_v;
    lat = 0;
    do begin
      @(posedge clk_50M); #1;
      lat++;
      if (lat == 1) begin
        snap_base = {base_ram_ce_n, base_ram_oe_n, base_ram_we_n};
        snap_ext = {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n};
        snap_baddr = base_ram_addr;
        snap_eaddr = ext_ram_addr;
        snap_ebe = ext_ram_be_n;
        snap_edata = ext_ram_data;
      end
    end while (!dut.cpu_ready && lat < 10);
    if (dut.cpu_ready !== 1'b1) begin
      nfail++;
      $error("FAIL timeout: no ready within %0d cycles for addr %h", lat, a);
    end
    rd = dut.cpu_rdata;
    req_v.req = 1'b0;
    force dut.cpu_req = req_v;
  endtask

  initial begin
    base_mem[0] <= 32'h3C08_8040;
    ext_mem[1] <= 32'h1122_3344;
    req_v = '0;
    #2 reset_btn = 1;
    #14 reset_btn = 0;
    repeat (2) @(posedge clk_50M);
    #1;
    `CHK("rst_flash_byte_n", flash_byte_n, 1'b1)
    `CHK("rst_flash_ce_n", flash_ce_n, 1'b1)
    `CHK("rst_flash_d", flash_d, 16'hzzzz)
    `CHK("rst_ram_strobes", {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 6'b111111)
    `CHK("rst_be_n", {base_ram_be_n, ext_ram_be_n}, 8'h00)
    `CHK("rst_base_data", base_ram_data, 32'hzzzzzzzz)
    `CHK("rst_txd", txd, 1'b1)
    `CHK("rst_leds", leds, 16'h0000)

    xfer(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    `CHK("base_rd_lat", lat, 2)
    `CHK("base_rd_data", rd, 32'h3C08_8040)
    `CHK("base_rd_strobes", snap_base, 3'b001)
    `CHK("base_rd_ext_idle", snap_ext, 3'b111)
    `CHK("base_rd_addr", snap_baddr, 20'h0)
    `CHK("base_rd_done_strobes", {base_ram_ce_n, base_ram_oe_n}, 2'b11)

    xfer(1'b1, 32'h8040_0004, 4'b0100, 32'hAABB_CCDD);
    `CHK("ext_wr_lat", lat, 2)
    `CHK("ext_wr_strobes", snap_ext, 3'b010)
    `CHK("ext_wr_base_idle", snap_base, 3'b111)
    `CHK("ext_wr_addr", snap_eaddr, 20'h1)
    `CHK("ext_wr_be_n", snap_ebe, 4'b1011)
    `CHK("ext_wr_data", snap_edata, 32'hAABB_CCDD)
    `CHK("ext_wr_done_we_n", ext_ram_we_n, 1'b1)
    xfer(1'b0, 32'h8040_0004, 4'hF, 32'h0);
    `CHK("ext_readback", rd, 32'h11BB_3344)

    xfer(1'b1, UART_DATA, 4'h1, 32'h41);
    e0 = cyc;
    `CHK("uart_wr_lat", lat, 1)
    xfer(1'b0, UART_STAT, 4'hF, 32'h0);
    `CHK("uart_stat_busy", rd, 32'h0)
    xfer(1'b1, UART_DATA, 4'h1, 32'h55);
    frame = {1'b1, 8'h41, 1'b0};
    for (int k = 0; k < 10; k++) begin
      while (cyc < e0 + 217 + k * 434) begin
        @(posedge clk_50M); #1;
      end
      `CHK("tx_bit", txd, frame[k])
    end
    while (cyc < e0 + 4360) begin
      @(posedge clk_50M); #1;
    end
    xfer(1'b0, UART_STAT, 4'hF, 32'h0);
    `CHK("uart_stat_idle", rd, 32'h1)
    `CHK("tx_idle_line", txd, 1'b1)

    frame = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = frame[k];
      repeat (434) @(posedge clk_50M);
    end
    repeat (20) @(posedge clk_50M);
    #1;
    xfer(1'b0, UART_STAT, 4'hF, 32'h0);
    `CHK("rx_stat_avail", rd, 32'h3)
    xfer(1'b0, UART_DATA, 4'hF, 32'h0);
    `CHK("rx_data", rd, 32'h0000_005A)
    xfer(1'b0, UART_STAT, 4'hF, 32'h0);
    `CHK("rx_stat_cleared", rd, 32'h1)

    xfer(1'b1, LED_ADDR, 4'hF, 32'h1234);
    `CHK("led_write", leds, 16'h1234)
    xfer(1'b1, LED_ADDR, 4'b0001, 32'hFFFF);
    `CHK("led_byte_en", leds, 16'h12FF)
    xfer(1'b0, LED_ADDR, 4'hF, 32'h0);
    `CHK("led_read", rd, 32'h0000_12FF)
    xfer(1'b0, 32'hA000_0000, 4'hF, 32'h0);
    `CHK("unmapped_lat", lat, 1)
    `CHK("unmapped_data", rd, 32'h0)

    xfer(1'b1, UART_DATA, 4'h1, 32'h0F);
    `CHK("abort_start_bit", txd, 1'b0)
    @(posedge clk_50M); #1;
    req_v = '{req: 1'b1, we: 1'b1, addr: 32'h8040_0008, be: 4'hF, wdata: 32'hDEAD_BEEF};
    force dut.cpu_req = req_v;
    @(posedge clk_50M); #1;
    `CHK("abort_we_low", ext_ram_we_n, 1'b0)
    reset_btn = 1;
    #1;
    `CHK("abort_strobes", {ext_ram_ce_n, ext_ram_we_n, ext_ram_be_n}, 6'b110000)
    `CHK("abort_txd", txd, 1'b1)
    `CHK("abort_leds", leds, 16'h0000)
    req_v.req = 1'b0;
    force dut.cpu_req = req_v;
    #5 reset_btn = 0;
    repeat (3) @(posedge clk_50M);
    if (nfail != 0) $error("FAIL summary: %0d checks failed", nfail);
    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end
endmodule
